tx_rr_arbiter: RTL and testbench
================================

# tx_rr_arbiter

Parametrised N-channel TX packet-header arbiter. It merges `CHNL_NUM` upstream header streams into one egress header stream using round-robin selection with a per-channel burst quota. The egress side is registered and tags each header with its source channel. It sits in the protocol engine TX path between the per-QP/per-engine header generators and the egress packet builder, replacing the fixed two-channel arbiter.

## Interface
- `CHNL_NUM`, 4, number of input channels, 2..16
- `HEAD_WIDTH`, `` `PKT_META_BUS_WIDTH ``, header width in bits
- `BURST_MAX`, 1, maximum consecutive grants to one channel while others wait; 1 gives plain round-robin; range 1..255
- `clk` input 1: single clock
- `rst` input 1: asynchronous, active-high reset
- `chnl_pkt_valid` input CHNL_NUM: per-channel header valid
- `chnl_pkt_head` input CHNL_NUM*HEAD_WIDTH: channel i occupies bits [i*HEAD_WIDTH +: HEAD_WIDTH]
- `chnl_pkt_ready` output CHNL_NUM: per-channel accept, at most one bit high per cycle
- `egress_pkt_valid` output 1: egress header valid
- `egress_pkt_head` output HEAD_WIDTH: selected header
- `egress_pkt_chnl` output CHNL_IDX_W = clog2(CHNL_NUM): source channel of the egress header
- `egress_pkt_ready` input 1: downstream accept

## Operation
- A transfer occurs on any interface when valid and ready are both high at the rising edge.
- Upstream holds valid and head stable until accepted. Downstream may hold ready low indefinitely.
- Output register: `out_vld`, `out_head`, `out_chnl`.
  - `load = ~out_vld | egress_pkt_ready`.
  - `chnl_pkt_ready[i] = load & pick_vld & (pick == i)`.
  - The grant is a function of valids and registered state only. It never depends on ready outputs.
- Arbitration state: `cur_chnl` (CHNL_IDX_W bits) and `burst_cnt` (clog2(BURST_MAX+1) bits).
- Pick rule, evaluated every cycle:
  - If `chnl_pkt_valid[cur_chnl]` and `burst_cnt < BURST_MAX`, pick `cur_chnl`.
  - Otherwise pick the first valid channel scanning from `cur_chnl+1`, wrapping modulo CHNL_NUM. `cur_chnl` itself is scanned last.
  - If no channel is valid, `pick_vld = 0`.
- On an accepted head from channel p:
  - If p == cur_chnl, `burst_cnt` increments, saturating at BURST_MAX.
  - Otherwise `cur_chnl <= p` and `burst_cnt <= 1`.
  - The output register loads the head, `out_chnl <= p` and `out_vld <= 1`.
- If `load` is high with no pick, `out_vld <= 0`.
- Egress valid, head and chnl stay stable while valid is high and ready is low.
- Wrap-around: the scan after channel CHNL_NUM-1 continues at channel 0. A lone valid channel is granted every load cycle regardless of quota, because it is scanned last.

## Timing
- Reset values: `egress_pkt_valid = 0`, `egress_pkt_head = 0`, `egress_pkt_chnl = 0`, `chnl_pkt_ready = 0`.
- Reset values of arbitration state: `cur_chnl = CHNL_NUM-1` and `burst_cnt = BURST_MAX`, so the first grant scans from channel 0.
- Latency: 1 cycle from channel accept to egress valid.
- Throughput: 1 header per cycle with `egress_pkt_ready` held high.
- Simultaneous egress accept and new load in the same cycle: the register is replaced with no bubble.
- Reset mid-operation: the output register and arbitration state clear immediately (asynchronously). Any held header is dropped. Upstream treats un-acked headers as still pending; acked ones are lost.

## Configuration
- `TX_ARB_STRICT_PRIO_EN` defined:
  - Channel 0 is strict-priority. If `chnl_pkt_valid[0]` is high, channel 0 is picked on every load cycle.
  - Channel 0 grants do not modify `cur_chnl` or `burst_cnt`.
  - Round-robin and quota apply only among channels 1..CHNL_NUM-1, scanning with channel 0 excluded.
- `TX_ARB_STRICT_PRIO_EN` undefined: channel 0 is an ordinary round-robin participant.

## Structure
- Shared header `protocol_engine_def.vh` holds `PKT_META_BUS_WIDTH`, a clog2 constant function and the `CHNL_IDX_W` derivation.
- Sub-module `tx_rr_pick`: a combinational rotating priority encoder.
  - Inputs: valid vector, start index, exclude-mask.
  - Outputs: `pick`, `pick_vld`.
  - It is reused for the strict-priority exclusion.
- The top level holds the quota counter, output register and ready decode.

## Test plan
- Reset: assert `rst` mid-stream with `egress_pkt_valid=1` -> all outputs 0 in the same cycle; after release, first grant goes to channel 0 when all channels are valid.
- Plain round-robin: CHNL_NUM=4, BURST_MAX=1, all valid, egress ready=1 -> `egress_pkt_chnl` sequence 0,1,2,3,0,1, one header per cycle.
- Quota: BURST_MAX=3, channels 1 and 2 valid continuously -> chnl sequence 1,1,1,2,2,2,1; lone channel 3 valid -> granted every cycle.
- Backpressure: egress ready low for 5 cycles -> valid/head/chnl stable, all `chnl_pkt_ready`=0; ready high -> next header follows with no bubble and none lost or duplicated.
- Sparse and wrap: only channels 3 and 0 valid alternately -> grants wrap from 3 to 0; idle cycles produce `egress_pkt_valid=0` after drain.
- With `TX_ARB_STRICT_PRIO_EN`: channels 0..3 valid, channel 0 drops after 2 heads -> chnl sequence 0,0,1,2,3; round-robin pointer unaffected by the channel-0 grants.

Source files
------------

// File: rtl/tx_rr_arbiter_pkg.sv
// tx_rr_arbiter_pkg
// Shared constants and helpers for the TX header arbiter slice.
//   PKT_META_BUS_WIDTH : default packet-header width in bits
//   clog2()            : ceiling log2, usable in parameter expressions
package tx_rr_arbiter_pkg;

   localparam int PKT_META_BUS_WIDTH = 32;

   // Ceiling log2. Returns 0 for an input of 1, so callers size indices
   // only for counts of two or more.
   function automatic int clog2(input int value);
      int result;
      int rem;
      result = 0;
      rem    = value - 1;
      while (rem > 0) begin
         result = result + 1;
         rem    = rem >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/tx_rr_arbiter_if.sv
// tx_rr_arbiter_if
// Bundles the upstream per-channel header streams and the egress header
// stream of the TX arbiter.
//   chnl_pkt_valid/head/ready : CHNL_NUM upstream valid/ready streams,
//                               channel i head at [i*HEAD_WIDTH +: HEAD_WIDTH]
//   egress_pkt_valid/head/chnl/ready : merged egress stream with source tag
// Modports: slave = arbiter side, master = header sources plus egress sink.
interface tx_rr_arbiter_if
   import tx_rr_arbiter_pkg::*;
#(
   parameter int CHNL_NUM   = 4,
   parameter int HEAD_WIDTH = PKT_META_BUS_WIDTH
) ();

   localparam int CHNL_IDX_W = clog2(CHNL_NUM);

   logic [CHNL_NUM-1:0]            chnl_pkt_valid;
   logic [CHNL_NUM*HEAD_WIDTH-1:0] chnl_pkt_head;
   logic [CHNL_NUM-1:0]            chnl_pkt_ready;
   logic                           egress_pkt_valid;
   logic [HEAD_WIDTH-1:0]          egress_pkt_head;
   logic [CHNL_IDX_W-1:0]          egress_pkt_chnl;
   logic                           egress_pkt_ready;

   modport slave (
      input  chnl_pkt_valid, chnl_pkt_head, egress_pkt_ready,
      output chnl_pkt_ready, egress_pkt_valid, egress_pkt_head, egress_pkt_chnl
   );

   modport master (
      output chnl_pkt_valid, chnl_pkt_head, egress_pkt_ready,
      input  chnl_pkt_ready, egress_pkt_valid, egress_pkt_head, egress_pkt_chnl
   );

endinterface

// File: rtl/tx_rr_arbiter_pick.sv
// tx_rr_pick
// Combinational rotating priority encoder: returns the first channel that
// is valid and not excluded, scanning upward from 'start' and wrapping.
//   valid    : per-channel request vector
//   start    : first channel index examined
//   exclude  : channels removed from the scan
//   pick     : selected channel index (0 when nothing is selected)
//   pick_vld : a channel was selected
module tx_rr_pick
   import tx_rr_arbiter_pkg::*;
#(
   parameter int CHNL_NUM = 4,
   localparam int CHNL_IDX_W = clog2(CHNL_NUM)
) (
   input  logic [CHNL_NUM-1:0]   valid,
   input  logic [CHNL_IDX_W-1:0] start,
   input  logic [CHNL_NUM-1:0]   exclude,
   output logic [CHNL_IDX_W-1:0] pick,
   output logic                  pick_vld
);

   // Walk all channels once starting at 'start'; the first eligible one
   // wins and later matches are ignored via pick_vld.
   always_comb begin
      int                  sum;
      logic [CHNL_IDX_W-1:0] idx;
      pick     = '0;
      pick_vld = 1'b0;
      sum      = 0;
      idx      = '0;
      for (int k = 0; k < CHNL_NUM; k++) begin
         sum = int'(start) + k;
         if (sum >= CHNL_NUM) begin
            sum = sum - CHNL_NUM;
         end
         idx = CHNL_IDX_W'(sum);
         if (!pick_vld && valid[idx] && !exclude[idx]) begin
            pick_vld = 1'b1;
            pick     = idx;
         end
      end
   end

endmodule

// File: rtl/tx_rr_arbiter.sv
// tx_rr_arbiter
// Merges CHNL_NUM upstream header streams into one registered egress stream
// using round-robin with a per-channel burst quota of BURST_MAX grants.
//   clk : clock
//   rst : asynchronous active-high reset
//   bus : tx_rr_arbiter_if.slave (upstream channels in, egress out)
// Optional build macro TX_ARB_STRICT_PRIO_EN: channel 0 becomes strict
// priority and is excluded from the round-robin rotation.
module tx_rr_arbiter
   import tx_rr_arbiter_pkg::*;
#(
   parameter int CHNL_NUM   = 4,
   parameter int HEAD_WIDTH = PKT_META_BUS_WIDTH,
   parameter int BURST_MAX  = 1
) (
   input logic              clk,
   input logic              rst,
   tx_rr_arbiter_if.slave   bus
);

   localparam int CHNL_IDX_W = clog2(CHNL_NUM);
   localparam int BURST_W    = clog2(BURST_MAX + 1);
   localparam logic [BURST_W-1:0]    BURST_LIMIT = BURST_W'(BURST_MAX);
   localparam logic [CHNL_IDX_W-1:0] LAST_CHNL   = CHNL_IDX_W'(CHNL_NUM - 1);
`ifdef TX_ARB_STRICT_PRIO_EN
   localparam logic [CHNL_NUM-1:0]   SCAN_EXCLUDE = CHNL_NUM'(1);
`else
   localparam logic [CHNL_NUM-1:0]   SCAN_EXCLUDE = '0;
`endif

   logic [CHNL_IDX_W-1:0] cur_chnl;
   logic [BURST_W-1:0]    burst_cnt;
   logic                  out_vld;
   logic [HEAD_WIDTH-1:0] out_head;
   logic [CHNL_IDX_W-1:0] out_chnl;

   logic [CHNL_IDX_W-1:0] scan_start;
   logic [CHNL_IDX_W-1:0] scan_pick;
   logic                  scan_vld;
   logic [CHNL_IDX_W-1:0] pick;
   logic                  pick_vld;
   logic                  load;
   logic                  accept;
   logic                  rr_grant;
   logic [HEAD_WIDTH-1:0] sel_head;

   // The scan begins just after the current channel so that the current
   // channel is examined last; this is what lets a lone requester keep
   // winning even after its quota is used up.
   always_comb begin
      scan_start = (cur_chnl == LAST_CHNL) ? '0 : cur_chnl + 1'b1;
   end

   tx_rr_pick #(
      .CHNL_NUM (CHNL_NUM)
   ) u_pick (
      .valid    (bus.chnl_pkt_valid),
      .start    (scan_start),
      .exclude  (SCAN_EXCLUDE),
      .pick     (scan_pick),
      .pick_vld (scan_vld)
   );

   // Final grant: stay on the current channel while it still has quota,
   // otherwise take the rotating scan result. With strict priority, channel
   // 0 overrides everything; cur_chnl can never be 0 in that build because
   // channel-0 grants never move the pointer.
   always_comb begin
      pick     = scan_pick;
      pick_vld = scan_vld;
`ifdef TX_ARB_STRICT_PRIO_EN
      if (bus.chnl_pkt_valid[0]) begin
         pick     = '0;
         pick_vld = 1'b1;
      end else if (bus.chnl_pkt_valid[cur_chnl] && (burst_cnt < BURST_LIMIT)) begin
         pick     = cur_chnl;
         pick_vld = 1'b1;
      end
`else
      if (bus.chnl_pkt_valid[cur_chnl] && (burst_cnt < BURST_LIMIT)) begin
         pick     = cur_chnl;
         pick_vld = 1'b1;
      end
`endif
   end

   // The output register may load whenever it is empty or being drained
   // this cycle, so back-to-back headers flow with no bubble.
   always_comb begin
      load     = ~out_vld | bus.egress_pkt_ready;
      accept   = load & pick_vld;
`ifdef TX_ARB_STRICT_PRIO_EN
      rr_grant = accept & (pick != '0);
`else
      rr_grant = accept;
`endif
      sel_head = bus.chnl_pkt_head[int'(pick)*HEAD_WIDTH +: HEAD_WIDTH];
   end

   // One-hot accept back to the granted channel. Held low during reset so
   // no source believes a header was taken while the register is clearing.
   always_comb begin
      bus.chnl_pkt_ready = '0;
      if (accept && !rst) begin
         bus.chnl_pkt_ready[pick] = 1'b1;
      end
   end

   // Round-robin pointer and quota counter. Reset parks the pointer on the
   // last channel with a spent quota so the first scan starts at channel 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_chnl  <= LAST_CHNL;
         burst_cnt <= BURST_LIMIT;
      end else if (rr_grant) begin
         if (pick == cur_chnl) begin
            if (burst_cnt != BURST_LIMIT) begin
               burst_cnt <= burst_cnt + 1'b1;
            end
         end else begin
            cur_chnl  <= pick;
            burst_cnt <= BURST_W'(1);
         end
      end
   end

   // Egress register: holds its contents while downstream stalls, and
   // empties when it is drained with nothing new to load.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_vld  <= 1'b0;
         out_head <= '0;
         out_chnl <= '0;
      end else if (load) begin
         out_vld <= pick_vld;
         if (pick_vld) begin
            out_head <= sel_head;
            out_chnl <= pick;
         end
      end
   end

   always_comb begin
      bus.egress_pkt_valid = out_vld;
      bus.egress_pkt_head  = out_head;
      bus.egress_pkt_chnl  = out_chnl;
   end

endmodule

// File: tb/tb_tx_rr_arbiter.sv
// tb_tx_rr_arbiter
// Directed bench for tx_rr_arbiter. Two instances are exercised: dut_rr
// with BURST_MAX=1 (plain round-robin, reset behaviour) and dut_q with
// BURST_MAX=3 (quota, lone channel, backpressure, sparse wrap and drain).
// Each source presents head {8'hA0, channel, sequence} and bumps its
// sequence number whenever the arbiter accepts it.
module tb_tx_rr_arbiter;
   import tx_rr_arbiter_pkg::*;

   logic clk = 1'b0;
   logic rst;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   logic [3:0]   vld     [2];
   logic         egr_rdy [2];
   int           seq     [2][4] = '{default: 0};
   int           exp_seq [2][4] = '{default: 0};
   int           exp_out [2];
   logic [127:0] head0;
   logic [127:0] head1;

   int rrSeq    [6] = '{0, 1, 2, 3, 0, 1};
   int prioSeq  [5] = '{0, 0, 1, 2, 3};
   int quotaSeq [7] = '{1, 1, 1, 2, 2, 2, 1};
   int resumeSeq[4] = '{1, 1, 1, 2};

   always #5 clk = ~clk;

   tx_rr_arbiter_if #(.CHNL_NUM(4), .HEAD_WIDTH(32)) bus0 ();
   tx_rr_arbiter_if #(.CHNL_NUM(4), .HEAD_WIDTH(32)) bus1 ();

   tx_rr_arbiter #(.CHNL_NUM(4), .HEAD_WIDTH(32), .BURST_MAX(1)) dut_rr (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   tx_rr_arbiter #(.CHNL_NUM(4), .HEAD_WIDTH(32), .BURST_MAX(3)) dut_q (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   function automatic logic [31:0] headOf(input int c, input int s);
      return {8'hA0, 8'(c), 16'(s)};
   endfunction

   // Source heads follow each channel's current sequence number.
   always_comb begin
      head0 = '0;
      head1 = '0;
      for (int c = 0; c < 4; c++) begin
         head0[c*32 +: 32] = headOf(c, seq[0][c]);
         head1[c*32 +: 32] = headOf(c, seq[1][c]);
      end
   end

   assign bus0.chnl_pkt_valid   = vld[0];
   assign bus0.chnl_pkt_head    = head0;
   assign bus0.egress_pkt_ready = egr_rdy[0];
   assign bus1.chnl_pkt_valid   = vld[1];
   assign bus1.chnl_pkt_head    = head1;
   assign bus1.egress_pkt_ready = egr_rdy[1];

   // A source advances to its next header once the current one is accepted.
   always @(posedge clk) begin
      for (int c = 0; c < 4; c++) begin
         if (vld[0][c] && bus0.chnl_pkt_ready[c]) seq[0][c] <= seq[0][c] + 1;
         if (vld[1][c] && bus1.chnl_pkt_ready[c]) seq[1][c] <= seq[1][c] + 1;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic readDut(input int d, output logic ov, output logic [31:0] oh,
                          output logic [1:0] oc, output logic [3:0] orr);
      if (d == 0) begin
         ov = bus0.egress_pkt_valid; oh = bus0.egress_pkt_head;
         oc = bus0.egress_pkt_chnl;  orr = bus0.chnl_pkt_ready;
      end else begin
         ov = bus1.egress_pkt_valid; oh = bus1.egress_pkt_head;
         oc = bus1.egress_pkt_chnl;  orr = bus1.chnl_pkt_ready;
      end
   endtask

   // One cycle: drive valids and egress ready, check the registered egress
   // against the expected occupant, and check that the hand-computed pick
   // (-1 = none) is the channel being accepted.
   task automatic applyStimulus(input int d, input logic [3:0] v, input logic r,
                                input int pick, input string tag);
      logic        ov;
      logic [31:0] oh;
      logic [1:0]  oc;
      logic [3:0]  orr;
      logic        load;
      logic [3:0]  exp_rdy;
      @(negedge clk);
      vld[d]     = v;
      egr_rdy[d] = r;
      #1;
      readDut(d, ov, oh, oc, orr);
      checkOutput({tag, "_vld"}, 32'(ov), 32'(exp_out[d] >= 0));
      if (exp_out[d] >= 0) begin
         checkOutput({tag, "_chnl"}, 32'(oc), 32'(exp_out[d]));
         checkOutput({tag, "_head"}, oh, headOf(exp_out[d], exp_seq[d][exp_out[d]]));
      end
      load    = (exp_out[d] < 0) || r;
      exp_rdy = (load && pick >= 0) ? 4'(1 << pick) : 4'b0000;
      checkOutput({tag, "_rdy"}, 32'(orr), 32'(exp_rdy));
      if (exp_out[d] >= 0 && r) exp_seq[d][exp_out[d]]++;
      if (load) exp_out[d] = pick;
   endtask

   initial begin
      logic        ov;
      logic [31:0] oh;
      logic [1:0]  oc;
      logic [3:0]  orr;

      rst        = 1'b1;
      vld[0]     = 4'b0000;
      vld[1]     = 4'b1111;
      egr_rdy[0] = 1'b0;
      egr_rdy[1] = 1'b0;
      exp_out[0] = -1;
      exp_out[1] = -1;

      // Reset state, including ready held low while requests are pending.
      repeat (2) @(negedge clk);
      #1;
      readDut(0, ov, oh, oc, orr);
      checkOutput("rst_vld", 32'(ov), 32'd0);
      checkOutput("rst_head", oh, 32'd0);
      checkOutput("rst_chnl", 32'(oc), 32'd0);
      readDut(1, ov, oh, oc, orr);
      checkOutput("rst_rdy_pending", 32'(orr), 32'd0);
      vld[1] = 4'b0000;
      @(negedge clk);
      rst = 1'b0;

`ifdef TX_ARB_STRICT_PRIO_EN
      // Channel 0 wins twice, then the untouched pointer starts at channel 1.
      for (int k = 0; k < 5; k++)
         applyStimulus(0, (k < 2) ? 4'b1111 : 4'b1110, 1'b1, prioSeq[k],
                       $sformatf("prio_%0d", k));
`else
      // Plain round-robin, one header per cycle.
      for (int k = 0; k < 6; k++)
         applyStimulus(0, 4'b1111, 1'b1, rrSeq[k], $sformatf("rr_%0d", k));
`endif

      // Reset while the egress register is occupied drops the held header.
      @(negedge clk);
      vld[0]     = 4'b1111;
      egr_rdy[0] = 1'b1;
      #1;
      readDut(0, ov, oh, oc, orr);
      checkOutput("mid_pre_vld", 32'(ov), 32'd1);
      checkOutput("mid_pre_chnl", 32'(oc), 32'(exp_out[0]));
      rst = 1'b1;
      #1;
      readDut(0, ov, oh, oc, orr);
      checkOutput("mid_rst_vld", 32'(ov), 32'd0);
      checkOutput("mid_rst_head", oh, 32'd0);
      checkOutput("mid_rst_chnl", 32'(oc), 32'd0);
      checkOutput("mid_rst_rdy", 32'(orr), 32'd0);
      exp_seq[0][exp_out[0]]++;
      exp_out[0] = -1;
      vld[0]     = 4'b0000;
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(0, 4'b1111, 1'b1, 0, "post_rst");
      applyStimulus(0, 4'b0000, 1'b1, -1, "post_rst_drain");
      applyStimulus(0, 4'b0000, 1'b1, -1, "post_rst_idle");

      // Quota of three between channels 1 and 2.
      for (int k = 0; k < 7; k++)
         applyStimulus(1, 4'b0110, 1'b1, quotaSeq[k], $sformatf("quota_%0d", k));

      // A lone channel keeps winning past its quota.
      for (int k = 0; k < 5; k++)
         applyStimulus(1, 4'b1000, 1'b1, 3, $sformatf("lone_%0d", k));

      // Five stalled cycles: egress frozen, nothing accepted.
      for (int k = 0; k < 5; k++)
         applyStimulus(1, 4'b0110, 1'b0, 1, $sformatf("stall_%0d", k));

      // Release: the next header follows with no bubble.
      for (int k = 0; k < 4; k++)
         applyStimulus(1, 4'b0110, 1'b1, resumeSeq[k], $sformatf("resume_%0d", k));

      // Sparse requests wrapping 3 -> 0, then drain to idle.
      applyStimulus(1, 4'b1000, 1'b1, 3, "wrap_0");
      applyStimulus(1, 4'b0001, 1'b1, 0, "wrap_1");
      applyStimulus(1, 4'b1000, 1'b1, 3, "wrap_2");
      applyStimulus(1, 4'b0001, 1'b1, 0, "wrap_3");
      applyStimulus(1, 4'b0000, 1'b1, -1, "drain_0");
      applyStimulus(1, 4'b0000, 1'b1, -1, "drain_1");
      applyStimulus(1, 4'b0000, 1'b1, -1, "drain_2");

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
